// File: rtl/ip_align_pkg.sv
// Shared types and constants for the align-core request sequencer.
// Each write-buffer entry holds one address/data pair.
package ip_align_pkg;

   // Values driven on err_wr.
   localparam logic REQ_RD = 1'b0;
   localparam logic REQ_WR = 1'b1;

   // Default widths. The buffer entry struct is sized from these.
   localparam int WIDTH_DEF      = 32;
   localparam int BITADDR_DEF    = 10;
   localparam int STARVE_MAX_DEF = 8;

   typedef struct packed {
      logic [BITADDR_DEF-1:0] adr;
      logic [WIDTH_DEF-1:0]   din;
   } wbuf_entry_t;

endpackage

// File: rtl/ip_align_wbuf.sv
// Circular write buffer with per-entry valid bits.
// A parallel address compare tells the arbiter when a read would overtake a buffered write.
module ip_align_wbuf
   import ip_align_pkg::*;
#(
   parameter int WBUFDEPTH = 4,
   parameter int BITWBUF   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wbuf_entry_t            push_entry,
   input  logic                   pop,
   input  logic [BITADDR_DEF-1:0] hit_adr,
   output logic                   hit,
   output wbuf_entry_t            head,
   output logic [BITWBUF:0]       cnt
);

   localparam logic [BITWBUF-1:0] PTR_LAST = BITWBUF'(WBUFDEPTH - 1);
   localparam logic [BITWBUF-1:0] PTR_ONE  = BITWBUF'(1);
   localparam logic [BITWBUF:0]   CNT_ONE  = (BITWBUF + 1)'(1);

   wbuf_entry_t          mem [WBUFDEPTH];
   logic [WBUFDEPTH-1:0] vld;
   logic [BITWBUF-1:0]   hd;
   logic [BITWBUF-1:0]   tl;

   // Pointer advance with explicit wrap, so non-power-of-two depths also work.
   function automatic logic [BITWBUF-1:0] nxt(input logic [BITWBUF-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   // Pointers, occupancy and valid bits; push and pop may both fire in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hd  <= '0;
         tl  <= '0;
         cnt <= '0;
         vld <= '0;
      end else begin
         if (pop) begin
            vld[hd] <= 1'b0;
            hd      <= nxt(hd);
         end
         if (push) begin
            vld[tl] <= 1'b1;
            tl      <= nxt(tl);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: ;
         endcase
      end
   end

   // Entry storage; contents are meaningless until the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (push) mem[tl] <= push_entry;
   end

   // Compare the read address against every stored entry.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < WBUFDEPTH; i++) begin
         if (vld[i] && (mem[i].adr == hit_adr)) hit = 1'b1;
      end
   end

   assign head = mem[hd];

endmodule

// File: rtl/ip_top_align_req_seq.sv
// Request sequencer for the single-port align core.
// Writes are buffered. Reads win unless they hit a buffered write or the starvation
// limit forces a drain. At most one core op is issued per cycle, registered.
module ip_top_align_req_seq
   import ip_align_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int NUMADDR    = 1024,
   parameter int BITADDR    = BITADDR_DEF,
   parameter int WBUFDEPTH  = 4,
   parameter int BITWBUF    = 2,
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int BITSTARVE  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_vld,
   input  logic [BITADDR-1:0] rd_adr,
   output logic               rd_rdy,
   input  logic               wr_vld,
   input  logic [BITADDR-1:0] wr_adr,
   input  logic [WIDTH-1:0]   wr_din,
   output logic               wr_rdy,
   output logic               read,
   output logic               write,
   output logic [BITADDR-1:0] addr,
   output logic [WIDTH-1:0]   din,
   output logic               err_vld,
   output logic               err_wr,
   output logic [BITADDR-1:0] err_adr,
   output logic [BITWBUF:0]   wbuf_cnt
);

   localparam logic [BITSTARVE-1:0] STARVE_LIM = BITSTARVE'(STARVE_MAX);
   localparam logic [BITSTARVE-1:0] STARVE_ONE = BITSTARVE'(1);

   wbuf_entry_t          push_entry;
   wbuf_entry_t          head;
   logic                 hit;
   logic                 push;
   logic                 pop;
   logic                 fifo_ne;
   logic                 rd_in;
   logic                 wr_in;
   logic                 hazard;
   logic                 force_drain;
   logic                 rd_issue;
   logic                 rd_oor;
   logic                 wr_issue;
   logic                 wr_acc;
   logic                 wr_err;
   logic [BITSTARVE-1:0] starve;

   // Request classification and issue arbitration.
   assign rd_in       = int'(rd_adr) < NUMADDR;
   assign wr_in       = int'(wr_adr) < NUMADDR;
   assign fifo_ne     = (wbuf_cnt != '0);
   assign hazard      = rd_vld && hit;
   assign force_drain = (starve == STARVE_LIM) && fifo_ne;
   assign rd_issue    = rd_vld && rd_in && !hazard && !force_drain;
   assign rd_oor      = rd_vld && !rd_in;
   assign wr_issue    = !rd_issue && fifo_ne;
   assign rd_rdy      = rd_issue || rd_oor;

   // Slot availability depends on the registered count only.
   assign wr_rdy      = int'(wbuf_cnt) < WBUFDEPTH;
   assign wr_acc      = wr_vld && wr_rdy;
   assign wr_err      = wr_acc && !wr_in;
   assign push        = wr_acc && wr_in && !rst;
   assign pop         = wr_issue && !rst;
   assign push_entry  = '{adr: wr_adr, din: wr_din};

   ip_align_wbuf #(
      .WBUFDEPTH (WBUFDEPTH),
      .BITWBUF   (BITWBUF)
   ) u_wbuf (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .hit_adr    (rd_adr),
      .hit        (hit),
      .head       (head),
      .cnt        (wbuf_cnt)
   );

   // Count reads issued past a non-empty buffer; any drain or empty buffer restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= '0;
      end else if (wr_issue || !fifo_ne) begin
         starve <= '0;
      end else if (rd_issue && (starve != STARVE_LIM)) begin
         starve <= starve + STARVE_ONE;
      end
   end

   // Core strobes and operands; addr and din hold while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         read  <= 1'b0;
         write <= 1'b0;
         addr  <= '0;
         din   <= '0;
      end else begin
         read  <= rd_issue;
         write <= wr_issue;
         if (rd_issue) begin
            addr <= rd_adr;
         end else if (wr_issue) begin
            addr <= head.adr;
            din  <= head.din;
         end
      end
   end

   // Out-of-range drop report; a read error hides a simultaneous write error.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_vld <= 1'b0;
         err_wr  <= 1'b0;
         err_adr <= '0;
      end else if (rd_oor) begin
         err_vld <= 1'b1;
         err_wr  <= REQ_RD;
         err_adr <= rd_adr;
      end else if (wr_err) begin
         err_vld <= 1'b1;
         err_wr  <= REQ_WR;
         err_adr <= wr_adr;
      end else begin
         err_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ip_top_align_req_seq.sv
// Scoreboard bench for the align request sequencer.
// A queue-based reference model predicts each cycle's handshakes and core/error output.
// A separate monitor pops the predictions one cycle later and compares them.
module tb_ip_top_align_req_seq;
   import ip_align_pkg::*;

   localparam int NA = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_vld, rd_rdy, wr_vld, wr_rdy;
   logic [9:0]  rd_adr, wr_adr, addr, err_adr;
   logic [31:0] wr_din, din;
   logic        read, write, err_vld, err_wr;
   logic [2:0]  wbuf_cnt;

   always #5 clk = ~clk;

   ip_top_align_req_seq #(.NUMADDR(NA)) dut (
      .clk(clk), .rst(rst),
      .rd_vld(rd_vld), .rd_adr(rd_adr), .rd_rdy(rd_rdy),
      .wr_vld(wr_vld), .wr_adr(wr_adr), .wr_din(wr_din), .wr_rdy(wr_rdy),
      .read(read), .write(write), .addr(addr), .din(din),
      .err_vld(err_vld), .err_wr(err_wr), .err_adr(err_adr),
      .wbuf_cnt(wbuf_cnt)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] adr;
      logic [31:0] din;
      logic        ev;
      logic        ew;
      logic [31:0] ea;
   } exp_t;

   typedef struct {
      logic [9:0]  adr;
      logic [31:0] din;
   } ent_t;

   exp_t sb[$];
   ent_t wq[$];
   int   starve = 0;
   int   checks = 0;
   int   failures = 0;

   // Pending requests (held until the model says they were consumed).
   logic        rv = 0, wv = 0, keep_rd = 0;
   logic [9:0]  ra = '0, wa = '0;
   logic [31:0] wd = '0;
   logic        exp_rrdy, exp_wrdy;
   logic        saw_full = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: one call per clock, using the inputs currently driven.
   task automatic model_step();
      logic fne, rin, win, hz, rdiss, rdoor, wriss, wacc;
      exp_t e;
      ent_t h;
      fne   = (wq.size() != 0);
      rin   = (int'(ra) < NA);
      win   = (int'(wa) < NA);
      hz    = 1'b0;
      foreach (wq[i]) if (wq[i].adr == ra) hz = 1'b1;
      rdiss = rv && rin && !hz && !(starve == 8 && fne);
      rdoor = rv && !rin;
      wriss = !rdiss && fne;
      wacc  = wv && (wq.size() < 4);
      exp_rrdy = rdiss || rdoor;
      exp_wrdy = (wq.size() < 4);
      chk("rd_rdy", rd_rdy, exp_rrdy);
      chk("wr_rdy", wr_rdy, exp_wrdy);
      chk("wbuf_cnt", wbuf_cnt, wq.size());
      if (wbuf_cnt == 3'd4) saw_full = 1'b1;
      e = '{default: '0};
      if (rdiss) begin
         e.rd = 1'b1; e.adr = ra;
      end else if (wriss) begin
         h = wq.pop_front();
         e.wr = 1'b1; e.adr = h.adr; e.din = h.din;
      end
      if (rdoor) begin
         e.ev = 1'b1; e.ew = 1'b0; e.ea = ra;
      end else if (wacc && !win) begin
         e.ev = 1'b1; e.ew = 1'b1; e.ea = wa;
      end
      if (e.rd || e.wr || e.ev) sb.push_back(e);
      if (wacc && win) wq.push_back('{adr: wa, din: wd});
      if (wriss || !fne) starve = 0;
      else if (rdiss && starve < 8) starve++;
   endtask

   task automatic cycle();
      @(negedge clk);
      rd_vld = rv; rd_adr = ra; wr_vld = wv; wr_adr = wa; wr_din = wd;
      #1;
      model_step();
      if (rv && exp_rrdy && !keep_rd) rv = 1'b0;
      if (wv && exp_wrdy) wv = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   // Cycle until the pending write is accepted, bounded.
   task automatic wait_wr(input string nm);
      for (int k = 0; k < 40 && wv; k++) cycle();
      chk(nm, wv, 1'b0);
   endtask

   task automatic wait_rd(input string nm);
      for (int k = 0; k < 40 && rv; k++) cycle();
      chk(nm, rv, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; rv = 0; wv = 0; keep_rd = 0;
      rd_vld = 0; wr_vld = 0;
      wq.delete(); starve = 0;
      @(negedge clk);
      chk("rst_wbuf_cnt", wbuf_cnt, 0);
      chk("rst_write", write, 0);
      chk("rst_read", read, 0);
      chk("rst_err_vld", err_vld, 0);
      rst = 1'b0;
   endtask

   function automatic logic [9:0] pick_adr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)      return 10'($urandom_range(0, 7));
      else if (r < 9) return 10'($urandom_range(0, NA - 1));
      else            return 10'($urandom_range(NA, 1023));
   endfunction

   // Monitor: pops one prediction whenever the DUT presents an output.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (read === 1'b1 || write === 1'b1 || err_vld === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", {read, write, err_vld}, 3'b000);
            end else begin
               e = sb.pop_front();
               chk("read", read, e.rd);
               chk("write", write, e.wr);
               if (e.rd || e.wr) chk("addr", addr, e.adr);
               if (e.wr) chk("din", din, e.din);
               chk("err_vld", err_vld, e.ev);
               if (e.ev) begin
                  chk("err_wr", err_wr, e.ew);
                  chk("err_adr", err_adr, e.ea);
               end
            end
         end else if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("missing_out", {read, write, err_vld}, {e.rd, e.wr, e.ev});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_vld = 0; rd_adr = '0; wr_vld = 0; wr_adr = '0; wr_din = '0;
      repeat (3) @(negedge clk);
      chk("reset_read", read, 0);
      chk("reset_write", write, 0);
      chk("reset_addr", addr, 0);
      chk("reset_din", din, 0);
      chk("reset_err_vld", err_vld, 0);
      chk("reset_err_wr", err_wr, 0);
      chk("reset_err_adr", err_adr, 0);
      chk("reset_wbuf_cnt", wbuf_cnt, 0);
      rst = 1'b0;

      // Lone write.
      wv = 1; wa = 10'd5; wd = 32'h1234;
      run(3);

      // Four writes under continuous read pressure: starvation forces drains.
      keep_rd = 1; rv = 1; ra = 10'd100;
      for (int i = 1; i <= 4; i++) begin
         wv = 1; wa = 10'(i); wd = $urandom;
         wait_wr("t2_wr_accept");
      end
      run(30);
      keep_rd = 0;
      wait_rd("t2_rd_done");
      run(6);

      // Read hitting a buffered write waits for the drain.
      wv = 1; wa = 10'd7; wd = 32'hCAFE0007;
      cycle();
      rv = 1; ra = 10'd7;
      wait_rd("t3_rd_done");
      run(3);

      // Fill the buffer while reads hold priority.
      saw_full = 0;
      keep_rd = 1; rv = 1; ra = 10'd200;
      for (int i = 0; i < 5; i++) begin
         wv = 1; wa = 10'(20 + i); wd = $urandom;
         wait_wr("t4_wr_accept");
      end
      chk("t4_saw_full", saw_full, 1'b1);
      keep_rd = 0;
      wait_rd("t4_rd_done");
      run(8);

      // Out-of-range read and write together, then a lone bad write; boundary read.
      rv = 1; ra = 10'd1000; wv = 1; wa = 10'd1010; wd = 32'h1;
      cycle();
      run(2);
      wv = 1; wa = 10'd1020; wd = 32'h2;
      cycle();
      run(2);
      rv = 1; ra = 10'd999;
      wait_rd("t5_rd_999");
      wv = 1; wa = 10'd999; wd = 32'h3;
      wait_wr("t5_wr_999");
      run(3);

      // Reset with three buffered writes: none may ever issue.
      keep_rd = 1; rv = 1; ra = 10'd300;
      for (int i = 0; i < 3; i++) begin
         wv = 1; wa = 10'(40 + i); wd = $urandom;
         wait_wr("t6_wr_accept");
      end
      cycle();
      do_reset();
      run(10);

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         if (!rv && $urandom_range(0, 9) < 7) begin rv = 1; ra = pick_adr(); end
         if (!wv && $urandom_range(0, 9) < 5) begin wv = 1; wa = pick_adr(); wd = $urandom; end
         cycle();
      end
      wait_wr("rand_wr_done");
      wait_rd("rand_rd_done");
      run(20);
      chk("sb_drained", sb.size(), 0);
      chk("final_wbuf_cnt", wbuf_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
